// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard query over a private two-slot shadow of EXE/MEM; zero-cycle match, slots advance each edge.
// A stall inserts a bubble into the EXE shadow and bumps a saturating stall counter; flush squashes the query.
module hazard_scoreboard #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [3:0]       src1,
   input  logic [3:0]       src2,
   input  logic             Two_src,
   input  logic             id_wb_en,
   input  logic             id_mem_r_en,
   input  logic [3:0]       id_dest,
   input  logic             flush,
   input  logic             forward_en,
   output logic             hazard,
   output logic [1:0]       hazard_src,
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic             r_e_v;
   logic             r_e_wb;
   logic             r_e_mr;
   logic [3:0]       r_e_dst;
   logic             r_m_v;
   logic             r_m_wb;
   logic [3:0]       r_m_dst;
   logic [CNT_W-1:0] r_stall_count;

   logic             w_me1;
   logic             w_mm1;
   logic             w_me2;
   logic             w_mm2;
   logic             w_c1;
   logic             w_c2;
   logic             w_qual;
   logic [1:0]       w_hazard_src;
   logic             w_hazard;
   logic             w_bubble;

   always_comb begin
      w_me1 = r_e_v & r_e_wb & (r_e_dst == src1);
      w_mm1 = r_m_v & r_m_wb & (r_m_dst == src1);
      w_me2 = r_e_v & r_e_wb & (r_e_dst == src2) & Two_src;
      w_mm2 = r_m_v & r_m_wb & (r_m_dst == src2) & Two_src;
      // With forwarding only a load still in EXE cannot be bypassed in time.
      if (forward_en) begin
         w_c1 = w_me1 & r_e_mr;
         w_c2 = w_me2 & r_e_mr;
      end else begin
         w_c1 = w_me1 | w_mm1;
         w_c2 = w_me2 | w_mm2;
      end
   end

   assign w_qual       = id_valid & ~flush;
   assign w_hazard_src = {w_c2, w_c1} & {2{w_qual}};
   assign w_hazard     = |w_hazard_src;
   assign w_bubble     = flush | w_hazard | ~id_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_e_v         <= 1'b0;
         r_e_wb        <= 1'b0;
         r_e_mr        <= 1'b0;
         r_e_dst       <= 4'd0;
         r_m_v         <= 1'b0;
         r_m_wb        <= 1'b0;
         r_m_dst       <= 4'd0;
         r_stall_count <= '0;
      end else begin
         r_m_v   <= r_e_v;
         r_m_wb  <= r_e_wb;
         r_m_dst <= r_e_dst;
         if (w_bubble) begin
            r_e_v   <= 1'b0;
            r_e_wb  <= 1'b0;
            r_e_mr  <= 1'b0;
            r_e_dst <= 4'd0;
         end else begin
            r_e_v   <= 1'b1;
            r_e_wb  <= id_wb_en;
            r_e_mr  <= id_mem_r_en;
            r_e_dst <= id_dest;
         end
         if (w_hazard && (r_stall_count != CNT_MAX)) begin
            r_stall_count <= r_stall_count + CNT_ONE;
         end
      end
   end

   assign hazard      = w_hazard;
   assign hazard_src  = w_hazard_src;
   assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random traffic against a pipeline-occupancy model.
module tb_hazard_scoreboard;

   localparam int CW   = 4;
   localparam int MAXC = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          id_valid = 1'b0;
   logic [3:0]    src1 = 4'd0;
   logic [3:0]    src2 = 4'd0;
   logic          Two_src = 1'b0;
   logic          id_wb_en = 1'b0;
   logic          id_mem_r_en = 1'b0;
   logic [3:0]    id_dest = 4'd0;
   logic          flush = 1'b0;
   logic          forward_en = 1'b0;
   logic          hazard;
   logic [1:0]    hazard_src;
   logic [CW-1:0] stall_count;

   int n_vec = 0;
   int n_err = 0;

   hazard_scoreboard #(.CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
      .Two_src(Two_src), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
      .id_dest(id_dest), .flush(flush), .forward_en(forward_en),
      .hazard(hazard), .hazard_src(hazard_src), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   // Model: in-flight instructions by pipeline distance; index 0 = one ahead (EXE), 1 = two ahead (MEM).
   typedef struct { bit v; bit wb; bit ld; bit [3:0] dst; } instr_t;
   instr_t ahead[2];
   int     m_cnt;

   function automatic bit producer_blocks(int k, bit [3:0] r, bit fwd);
      if (!(ahead[k].v && ahead[k].wb && ahead[k].dst == r)) return 1'b0;
      if (!fwd) return 1'b1;
      return (k == 0) && ahead[k].ld;
   endfunction

   function automatic bit [1:0] model_src();
      bit [1:0] c = 2'b00;
      if (!id_valid || flush) return 2'b00;
      for (int k = 0; k < 2; k++) begin
         if (producer_blocks(k, src1, forward_en)) c[0] = 1'b1;
         if (Two_src && producer_blocks(k, src2, forward_en)) c[1] = 1'b1;
      end
      return c;
   endfunction

   task automatic apply(input bit v, input bit [3:0] s1, input bit [3:0] s2, input bit two,
                        input bit wb, input bit ld, input bit [3:0] d, input bit fl,
                        input bit fw, input bit r);
      id_valid = v; src1 = s1; src2 = s2; Two_src = two; id_wb_en = wb;
      id_mem_r_en = ld; id_dest = d; flush = fl; forward_en = fw; rst = r;
      @(negedge clk);
   endtask

   task automatic tick();
      bit [1:0] eh;
      eh = model_src();
      if (rst) begin
         ahead[0] = '{0, 0, 0, 4'd0};
         ahead[1] = '{0, 0, 0, 4'd0};
         m_cnt = 0;
      end else begin
         ahead[1] = ahead[0];
         if (flush || eh != 2'b00 || !id_valid) ahead[0] = '{0, 0, 0, 4'd0};
         else ahead[0] = '{1'b1, id_wb_en, id_mem_r_en, id_dest};
         if (eh != 2'b00 && m_cnt < MAXC) m_cnt++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      apply(0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1);
      tick();
   endtask

   task automatic test_reset();
      apply($urandom, 4'($urandom), 4'($urandom), $urandom, $urandom, $urandom, 4'($urandom), 0, $urandom, 1);
      tick();
      do_reset();
      apply(1, 4'd0, 4'd0, 1, 1, 1, 4'd0, 0, 0, 0);
      n_vec++;
      if (hazard !== 1'b0 || hazard_src !== 2'b00 || stall_count !== 4'd0) begin
         n_err++;
         $display("FAIL reset: hazard=%b src=%b cnt=%0d, want 0/00/0", hazard, hazard_src, stall_count);
      end
      tick();
   endtask

   task automatic test_raw_exe();
      do_reset();
      apply(1, 4'hF, 4'h0, 0, 1, 0, 4'd3, 0, 0, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         apply(1, 4'd3, 4'd0, 0, 1, 0, 4'd8, 0, 0, 0);
         n_vec++;
         if (hazard !== (i < 2) || hazard_src !== ((i < 2) ? 2'b01 : 2'b00)) begin
            n_err++;
            $display("FAIL raw_exe cyc%0d: hazard=%b src=%b", i, hazard, hazard_src);
         end
         tick();
      end
      apply(0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0);
      n_vec++;
      if (stall_count !== 4'd2) begin
         n_err++;
         $display("FAIL raw_exe count: got %0d want 2", stall_count);
      end
      tick();
   endtask

   task automatic test_two_src();
      do_reset();
      apply(1, 4'hF, 4'h0, 0, 1, 0, 4'd5, 0, 0, 0);
      tick();
      apply(1, 4'd1, 4'd5, 0, 1, 0, 4'd9, 0, 0, 0);
      n_vec++;
      if (hazard !== 1'b0) begin
         n_err++;
         $display("FAIL two_src off: hazard=%b want 0", hazard);
      end
      Two_src = 1'b1;
      #1;
      n_vec++;
      if (hazard !== 1'b1 || hazard_src !== 2'b10) begin
         n_err++;
         $display("FAIL two_src on: hazard=%b src=%b want 1/10", hazard, hazard_src);
      end
      tick();
   endtask

   task automatic test_forwarding();
      do_reset();
      apply(1, 4'hF, 4'h0, 0, 1, 0, 4'd4, 0, 1, 0);
      tick();
      apply(1, 4'd4, 4'd0, 0, 1, 0, 4'd1, 0, 1, 0);
      n_vec++;
      if (hazard !== 1'b0) begin
         n_err++;
         $display("FAIL fwd alu: hazard=%b want 0", hazard);
      end
      tick();
      do_reset();
      apply(1, 4'hF, 4'h0, 0, 1, 1, 4'd4, 0, 1, 0);
      tick();
      for (int i = 0; i < 2; i++) begin
         apply(1, 4'd4, 4'd0, 0, 1, 0, 4'd1, 0, 1, 0);
         n_vec++;
         if (hazard !== (i == 0)) begin
            n_err++;
            $display("FAIL fwd load cyc%0d: hazard=%b want %0d", i, hazard, (i == 0));
         end
         tick();
      end
   endtask

   task automatic test_flush();
      logic [CW-1:0] c0;
      do_reset();
      apply(1, 4'hF, 4'h0, 0, 1, 0, 4'd2, 0, 0, 0);
      tick();
      apply(1, 4'd2, 4'd0, 0, 1, 0, 4'd7, 1, 0, 0);
      c0 = stall_count;
      n_vec++;
      if (hazard !== 1'b0 || hazard_src !== 2'b00) begin
         n_err++;
         $display("FAIL flush query: hazard=%b src=%b want 0/00", hazard, hazard_src);
      end
      tick();
      for (int i = 0; i < 2; i++) begin
         apply(1, 4'd7, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0);
         n_vec++;
         if (hazard !== 1'b0 || stall_count !== c0) begin
            n_err++;
            $display("FAIL flush squash cyc%0d: hazard=%b cnt=%0d want 0/%0d", i, hazard, stall_count, c0);
         end
         tick();
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 36; i++) begin
         apply(1, 4'd6, 4'd0, 0, 1, 0, 4'd6, 0, 0, 0);
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         apply(1, 4'd6, 4'd0, 0, 1, 0, 4'd6, 0, 0, 0);
         n_vec++;
         if (stall_count !== 4'd15) begin
            n_err++;
            $display("FAIL saturation cyc%0d: cnt=%0d want 15", i, stall_count);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      apply(1, 4'hF, 4'h0, 0, 1, 0, 4'd9, 0, 0, 0);
      tick();
      apply(1, 4'd9, 4'd0, 0, 1, 0, 4'd1, 0, 0, 0);
      n_vec++;
      if (hazard !== 1'b1) begin
         n_err++;
         $display("FAIL mid_stall pre: hazard=%b want 1", hazard);
      end
      tick();
      apply(1, 4'd9, 4'd0, 0, 1, 0, 4'd1, 0, 0, 1);
      tick();
      apply(1, 4'd9, 4'd0, 0, 1, 0, 4'd1, 0, 0, 0);
      n_vec++;
      if (hazard !== 1'b0 || stall_count !== 4'd0) begin
         n_err++;
         $display("FAIL mid_stall post: hazard=%b cnt=%0d want 0/0", hazard, stall_count);
      end
      tick();
   endtask

   task automatic test_random();
      bit [1:0] eh;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         // Narrow register range so RAW conflicts are frequent.
         apply(($urandom % 8) != 0, 4'($urandom % 4), 4'($urandom % 4), $urandom, $urandom,
               ($urandom % 3) == 0, 4'($urandom % 4), ($urandom % 8) == 0, i >= 200,
               ($urandom % 64) == 0);
         eh = model_src();
         n_vec++;
         if (hazard_src !== eh || hazard !== (eh != 2'b00) || stall_count !== CW'(m_cnt)) begin
            n_err++;
            $display("FAIL random cyc%0d: hazard=%b src=%b cnt=%0d want %b/%b/%0d",
                     i, hazard, hazard_src, stall_count, (eh != 2'b00), eh, m_cnt);
         end
         tick();
      end
   endtask

   initial begin
      ahead[0] = '{0, 0, 0, 4'd0};
      ahead[1] = '{0, 0, 0, 4'd0};
      m_cnt = 0;
      test_reset();
      test_raw_exe();
      test_two_src();
      test_forwarding();
      test_flush();
      test_saturation();
      test_reset_mid_stall();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
